// File: rtl/mc_ctrl_pkg.sv
// Shared state, shift, ALU and condition encodings for the multicycle control unit.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_RSREAD,
        S_EXECR,
        S_EXECI,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_ALUWB,
        S_BRANCH
    } state_t;

    // Barrel-shifter operation codes
    localparam logic [2:0] SH_NONE = 3'b000;
    localparam logic [2:0] SH_LSL  = 3'b001;
    localparam logic [2:0] SH_LSR  = 3'b010;
    localparam logic [2:0] SH_ASR  = 3'b011;
    localparam logic [2:0] SH_RRX  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;

    // ALU codes are the ARM data-processing opcode field
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;
    localparam logic [3:0] ALU_ORR = 4'b1100;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv = {N, Z, C, V}; 1111 (never) falls to the default
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = !z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = !c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = !n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = !v;
            COND_HI: cond_holds = c && !z;
            COND_LS: cond_holds = !c || z;
            COND_GE: cond_holds = (n == v);
            COND_LT: cond_holds = (n != v);
            COND_GT: cond_holds = !z && (n == v);
            COND_LE: cond_holds = z || (n != v);
            COND_AL: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

    // TST/TEQ/CMP/CMN: flags only, no register result
    function automatic logic is_compare(input logic [3:0] code);
        is_compare = (code == ALU_TST) || (code == ALU_TEQ) ||
                     (code == ALU_CMP) || (code == ALU_CMN);
    endfunction

    // Arithmetic ops (SUB..RSC, CMP, CMN) produce meaningful C and V
    function automatic logic writes_cv(input logic [3:0] code);
        writes_cv = ((code >= ALU_SUB) && (code <= 4'b0111)) ||
                    (code == ALU_CMP) || (code == ALU_CMN);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register with split NZ / CV write enables, plus condition-pass evaluation.
// Latency: flags written on the clock edge ending the write cycle; cond_ex is combinational.
// Backpressure: none.
// Ports: clk, reset_n (async active-low); cond = Instr[31:28]; alu_flags = NZCV from ALU;
//        flag_w = {NZ write, CV write}; flags = current NZCV; cond_ex = condition passes.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic [3:0] flags,
    output logic       cond_ex
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign cond_ex = cond_holds(cond, flags);

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: fetch/decode/RSR read/execute/memory/writeback sequencing for the ARM subset.
// Latency: 2..5 cycles per instruction at MEM_LAT=0, plus MEM_LAT per fetch and per memory access.
// Backpressure: fixed memory latency; FETCH, MEMRD and MEMWR hold their outputs until the wait counter reaches MEM_LAT.
// Ports: instruction fields Cond/Op/Funct/Rd/Src2 from the IR; ALUFlags from the ALU; all datapath
//        enables and selects out; Undef pulses in DECODE on unimplemented encodings; Flags = NZCV.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 0,
    parameter int RSR_EN  = 1,
    parameter int ALUC_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic [11:0]       Src2,
    input  logic [3:0]        ALUFlags,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemW,
    output logic              IRWrite,
    output logic              RegW,
    output logic              ALUSrcA,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [2:0]        ShiftOp,
    output logic              ShAmtReg,
    output logic              RsRead,
    output logic              Undef,
    output logic [3:0]        Flags
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       mem_done;
    logic       mem_state;
    logic       cond_ex;
    logic [1:0] flag_w;
    logic [3:0] alu_op;
    logic [3:0] alu_code;
    logic       s_bit;
    logic       rd_is_pc;
    logic       imm_amt_zero;
    logic [2:0] shift_dec;

    // Src2[3:0] is Rm, consumed by the register file directly
    logic unused_rm;
    assign unused_rm = ^Src2[3:0];

    assign alu_code = Funct[4:1];
    // Compares always set flags regardless of the S bit
    assign s_bit    = Funct[0] | is_compare(alu_code);
    assign rd_is_pc = (Rd == 4'd15);

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign mem_done  = (wait_cnt == LAT);

    cond_unit u_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .flags     (Flags),
        .cond_ex   (cond_ex)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (mem_state && !mem_done) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    // Shift decode for register operands. A zero immediate amount turns LSL into
    // no shift and ROR into RRX; register-specified amounts keep the plain type.
    always_comb begin
        imm_amt_zero = !Src2[4] && (Src2[11:7] == 5'd0);
        case (Src2[6:5])
            2'b00:   shift_dec = imm_amt_zero ? SH_NONE : SH_LSL;
            2'b01:   shift_dec = SH_LSR;
            2'b10:   shift_dec = SH_ASR;
            default: shift_dec = imm_amt_zero ? SH_RRX : SH_ROR;
        endcase
    end

    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        RegW      = 1'b0;
        ALUSrcA   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 2'b00;
        RegSrc    = 2'b00;
        alu_op    = ALU_AND;
        ShiftOp   = SH_NONE;
        ShAmtReg  = 1'b0;
        RsRead    = 1'b0;
        Undef     = 1'b0;
        flag_w    = 2'b00;

        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                alu_op    = ALU_ADD;
                if (mem_done) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC+8 computation; the ALU must add here
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                alu_op    = ALU_ADD;
                if (!cond_ex) begin
                    state_nxt = S_FETCH;
                end else begin
                    case (Op)
                        2'b00: begin
                            if (Funct[5]) begin
                                state_nxt = S_EXECI;
                            end else if (Src2[4]) begin
                                if (RSR_EN != 0) begin
                                    state_nxt = S_RSREAD;
                                end else begin
                                    state_nxt = S_FETCH;
                                    Undef     = 1'b1;
                                end
                            end else begin
                                state_nxt = S_EXECR;
                            end
                        end
                        2'b01:   state_nxt = S_MEMADR;
                        2'b10:   state_nxt = S_BRANCH;
                        default: begin
                            state_nxt = S_FETCH;
                            Undef     = 1'b1;
                        end
                    endcase
                end
            end
            S_RSREAD: begin
                RsRead    = 1'b1;
                state_nxt = S_EXECR;
            end
            S_EXECR, S_EXECI: begin
                alu_op   = alu_code;
                ALUSrcB  = (state == S_EXECI) ? 2'b01 : 2'b00;
                ShiftOp  = (state == S_EXECR) ? shift_dec : SH_NONE;
                // Only the RSR path reaches EXECR with Src2[4] set
                ShAmtReg = (state == S_EXECR) && Src2[4];
                flag_w   = {s_bit, s_bit & writes_cv(alu_code)};
                state_nxt = is_compare(alu_code) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
                PCWrite   = rd_is_pc;
                state_nxt = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b01;
                alu_op    = ALU_ADD;
                state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_done) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCWrite   = rd_is_pc;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe held for the whole access, not just the last cycle
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                RegSrc = 2'b10;
                if (mem_done) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                // Target = PC+8 + offset, so the ALU adds
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                RegSrc    = 2'b01;
                ResultSrc = 2'b10;
                alu_op    = ALU_ADD;
                PCWrite   = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign ALUControl = ALUC_W'(alu_op);

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: three instances with different memory latency / RSR support,
// each instruction turned into an expected per-cycle output trace by a behavioural model.
module tb_mc_controller;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{0, 2, 3};
    localparam int RSRS [NDUT] = '{1, 0, 1};

    typedef struct packed {
        logic       pcw, adrsrc, memw, irw, regw, srca;
        logic [1:0] resultsrc, srcb, immsrc, regsrc;
        logic [3:0] aluc;
        logic [2:0] shop;
        logic       shamt, rsread, undef;
        logic [3:0] flags;
    } rec_t;

    logic        clk, reset_n;
    logic [3:0]  cond, rd, alu_flags;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [11:0] src2;

    logic       pc_write [NDUT], adr_src [NDUT], mem_w [NDUT], ir_write [NDUT], reg_w [NDUT];
    logic       alu_src_a [NDUT], sh_amt_reg [NDUT], rs_read [NDUT], undef [NDUT];
    logic [1:0] result_src [NDUT], alu_src_b [NDUT], imm_src [NDUT], reg_src [NDUT];
    logic [3:0] alu_control [NDUT], flags [NDUT];
    logic [2:0] shift_op [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mc_controller #(.MEM_LAT(LATS[g]), .RSR_EN(RSRS[g]), .ALUC_W(4)) u_dut (
            .clk(clk), .reset_n(reset_n), .Cond(cond), .Op(op), .Funct(funct), .Rd(rd),
            .Src2(src2), .ALUFlags(alu_flags), .PCWrite(pc_write[g]), .AdrSrc(adr_src[g]),
            .MemW(mem_w[g]), .IRWrite(ir_write[g]), .RegW(reg_w[g]), .ALUSrcA(alu_src_a[g]),
            .ResultSrc(result_src[g]), .ALUSrcB(alu_src_b[g]), .ImmSrc(imm_src[g]),
            .RegSrc(reg_src[g]), .ALUControl(alu_control[g]), .ShiftOp(shift_op[g]),
            .ShAmtReg(sh_amt_reg[g]), .RsRead(rs_read[g]), .Undef(undef[g]), .Flags(flags[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    rec_t exp_q [$];
    bit   dc_q [$];
    logic [3:0] mflags [NDUT];
    int n_memw, n_regw, n_pcw, n_irw, n_undef, n_rsread;

    function automatic rec_t get_act(input int k);
        rec_t r;
        r.pcw = pc_write[k];      r.adrsrc = adr_src[k];     r.memw = mem_w[k];
        r.irw = ir_write[k];      r.regw = reg_w[k];         r.srca = alu_src_a[k];
        r.resultsrc = result_src[k]; r.srcb = alu_src_b[k];  r.immsrc = imm_src[k];
        r.regsrc = reg_src[k];    r.aluc = alu_control[k];   r.shop = shift_op[k];
        r.shamt = sh_amt_reg[k];  r.rsread = rs_read[k];     r.undef = undef[k];
        r.flags = flags[k];
        return r;
    endfunction

    // Conditions come in pass/inverse pairs; Cond[0] selects the inverse.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [2:0] shift_exp(input logic [11:0] s);
        bit imm_zero;
        imm_zero = !s[4] && (s[11:7] == 5'd0);
        case (s[6:5])
            2'b00: return imm_zero ? 3'd0 : 3'd1;
            2'b01: return 3'd2;
            2'b10: return 3'd3;
            default: return imm_zero ? 3'd4 : 3'd5;
        endcase
    endfunction

    function automatic rec_t fetch_rec(input bit last, input logic [3:0] f);
        rec_t r;
        r = '0; r.srca = 1'b1; r.srcb = 2'b10; r.aluc = 4'b0100; r.resultsrc = 2'b10;
        r.irw = last; r.pcw = last; r.flags = f;
        return r;
    endfunction

    task automatic push(input rec_t r, input bit dc);
        exp_q.push_back(r);
        dc_q.push_back(dc);
    endtask

    // Expected cycle-by-cycle outputs for the instruction on the inputs, instance k.
    // ALUControl is left unchecked in DECODE and BRANCH (dc=1).
    task automatic build_trace(input int k);
        rec_t r;
        logic [3:0] f, code;
        bit s, cmp;
        f = mflags[k];
        code = funct[4:1];
        cmp = (code >= 4'd8) && (code <= 4'd11);
        exp_q.delete();
        dc_q.delete();
        for (int i = 0; i <= LATS[k]; i++) push(fetch_rec(i == LATS[k], f), 1'b0);
        r = '0; r.srca = 1'b1; r.srcb = 2'b10; r.resultsrc = 2'b10; r.flags = f;
        if (!cond_ok(cond, f)) begin
            push(r, 1'b1);
            return;
        end
        if (op == 2'b11 || (op == 2'b00 && !funct[5] && src2[4] && RSRS[k] == 0)) begin
            r.undef = 1'b1;
            push(r, 1'b1);
            return;
        end
        push(r, 1'b1);
        case (op)
            2'b00: begin
                if (!funct[5] && src2[4]) begin
                    r = '0; r.rsread = 1'b1; r.flags = f; push(r, 1'b0);
                end
                r = '0; r.aluc = code; r.flags = f;
                r.srcb = funct[5] ? 2'b01 : 2'b00;
                r.shop = funct[5] ? 3'd0 : shift_exp(src2);
                r.shamt = !funct[5] && src2[4];
                push(r, 1'b0);
                s = funct[0] || cmp;
                if (s) f[3:2] = alu_flags[3:2];
                if (s && ((code >= 4'd2 && code <= 4'd7) || code == 4'd10 || code == 4'd11))
                    f[1:0] = alu_flags[1:0];
                if (!cmp) begin
                    r = '0; r.regw = 1'b1; r.pcw = (rd == 4'd15); r.flags = f; push(r, 1'b0);
                end
            end
            2'b01: begin
                r = '0; r.srcb = 2'b01; r.immsrc = 2'b01; r.aluc = 4'b0100; r.flags = f;
                push(r, 1'b0);
                for (int i = 0; i <= LATS[k]; i++) begin
                    r = '0; r.adrsrc = 1'b1; r.flags = f;
                    if (!funct[0]) begin r.memw = 1'b1; r.regsrc = 2'b10; end
                    push(r, 1'b0);
                end
                if (funct[0]) begin
                    r = '0; r.resultsrc = 2'b01; r.regw = 1'b1; r.pcw = (rd == 4'd15); r.flags = f;
                    push(r, 1'b0);
                end
            end
            default: begin
                r = '0; r.srcb = 2'b01; r.immsrc = 2'b10; r.regsrc = 2'b01;
                r.resultsrc = 2'b10; r.pcw = 1'b1; r.flags = f;
                push(r, 1'b1);
            end
        endcase
        mflags[k] = f;
    endtask

    // Entered on a falling edge with instance k in its first FETCH cycle.
    task automatic run_trace(input int k, input int limit);
        rec_t act, e;
        int n;
        build_trace(k);
        n = (limit < exp_q.size()) ? limit : exp_q.size();
        n_memw = 0; n_regw = 0; n_pcw = 0; n_irw = 0; n_undef = 0; n_rsread = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            act = get_act(k);
            e = exp_q[i];
            if (dc_q[i]) act.aluc = e.aluc;
            n_memw += int'(act.memw); n_regw += int'(act.regw); n_pcw += int'(act.pcw);
            n_irw += int'(act.irw); n_undef += int'(act.undef); n_rsread += int'(act.rsread);
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL trace dut=%0d cyc=%0d cond=%h op=%0d funct=%b src2=%h actual=%h required=%h",
                         k, i, cond, op, funct, src2, act, e);
            end
        end
        if (n == exp_q.size()) @(negedge clk);
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                             input logic [3:0] d, input logic [11:0] s, input logic [3:0] af);
        cond = c; op = o; funct = fn; rd = d; src2 = s; alu_flags = af;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        foreach (mflags[i]) mflags[i] = 4'b0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_cnt(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic test_reset();
        rec_t act, e;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        act = get_act(1);
        e = fetch_rec(1'b0, 4'b0000);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL reset_outputs_lat2 actual=%h required=%h", act, e);
        end
        checks++;
        if (ir_write[0] !== 1'b1 || pc_write[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_irwrite_lat0 actual=%b%b required=11", ir_write[0], pc_write[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        foreach (mflags[i]) mflags[i] = 4'b0000;
        set_instr(4'hF, 2'b00, 6'b001000, 4'd0, 12'h002, 4'h0);
        run_trace(1, 1000);
        check_cnt("reset_fetch_irwrite_pulses", n_irw, 1);
        check_cnt("reset_fetch_pcwrite_pulses", n_pcw, 1);
    endtask

    task automatic test_subs();
        do_reset();
        set_instr(4'hE, 2'b00, 6'b100101, 4'd1, 12'h001, 4'b0110);
        run_trace(0, 1000);
        checks++;
        if (flags[0] !== 4'b0110) begin
            failures++;
            $display("FAIL subs_flags actual=%b required=0110", flags[0]);
        end
        check_cnt("subs_regw", n_regw, 1);
        // NE with Z now set must not execute
        set_instr(4'h1, 2'b00, 6'b001000, 4'd3, 12'h002, 4'b1111);
        run_trace(0, 1000);
        check_cnt("ne_after_subs_regw", n_regw, 0);
    endtask

    task automatic test_cond_exec();
        do_reset();
        set_instr(4'h0, 2'b00, 6'b001000, 4'd0, 12'h002, 4'b0000);
        run_trace(0, 1000);
        check_cnt("addeq_z0_regw", n_regw, 0);
        check_cnt("addeq_z0_memw", n_memw, 0);
        set_instr(4'hE, 2'b00, 6'b110101, 4'd0, 12'h000, 4'b0100);
        run_trace(0, 1000);
        check_cnt("cmp_regw", n_regw, 0);
        set_instr(4'h0, 2'b00, 6'b001000, 4'd0, 12'h002, 4'b0000);
        run_trace(0, 1000);
        check_cnt("addeq_z1_regw", n_regw, 1);
    endtask

    task automatic test_rsr();
        do_reset();
        set_instr(4'hE, 2'b00, 6'b001000, 4'd0, 12'h312, 4'b0000);
        run_trace(0, 1000);
        check_cnt("rsr_rsread", n_rsread, 1);
        do_reset();
        run_trace(1, 1000);
        check_cnt("rsr_disabled_undef", n_undef, 1);
        check_cnt("rsr_disabled_regw", n_regw, 0);
    endtask

    task automatic test_mem();
        do_reset();
        set_instr(4'hE, 2'b01, 6'b011000, 4'd2, 12'h004, 4'b0000);
        run_trace(2, 1000);
        check_cnt("str_lat3_memw_cycles", n_memw, 4);
        do_reset();
        set_instr(4'hE, 2'b01, 6'b011001, 4'd15, 12'h008, 4'b0000);
        run_trace(0, 1000);
        check_cnt("ldr_pc_pcwrite", n_pcw, 2);
        check_cnt("ldr_pc_regw", n_regw, 1);
    endtask

    task automatic test_undef_rrx();
        do_reset();
        set_instr(4'hE, 2'b11, 6'b000000, 4'd0, 12'h000, 4'b1111);
        run_trace(0, 1000);
        check_cnt("op11_undef", n_undef, 1);
        checks++;
        if (flags[0] !== 4'b0000) begin
            failures++;
            $display("FAIL op11_flags actual=%b required=0000", flags[0]);
        end
        set_instr(4'hE, 2'b00, 6'b011010, 4'd0, 12'h061, 4'b0000);
        run_trace(0, 1000);
    endtask

    task automatic test_reset_abort();
        rec_t act, e;
        do_reset();
        set_instr(4'hE, 2'b01, 6'b011000, 4'd2, 12'h004, 4'b0000);
        run_trace(2, 8);   // stop inside the MEMWR wait
        #1;
        reset_n = 1'b0;
        #1;
        act = get_act(2);
        e = fetch_rec(1'b0, 4'b0000);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL reset_abort actual=%h required=%h", act, e);
        end
        @(negedge clk);
        reset_n = 1'b1;
        foreach (mflags[i]) mflags[i] = 4'b0000;
    endtask

    task automatic test_random();
        for (int k = 0; k < NDUT; k++) begin
            do_reset();
            for (int n = 0; n < 40; n++) begin
                set_instr($urandom_range(0, 1) != 0 ? 4'hE : 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 6'($urandom), 
                          $urandom_range(0, 3) == 0 ? 4'd15 : 4'($urandom),
                          12'($urandom), 4'($urandom));
                run_trace(k, 1000);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_instr(4'hE, 2'b00, 6'b000000, 4'd0, 12'h000, 4'h0);
        foreach (mflags[i]) mflags[i] = 4'b0000;
        test_reset();
        test_subs();
        test_cond_exec();
        test_rsr();
        test_mem();
        test_undef_rrx();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
